// File: rtl/mem_arbiter.sv
// Byte-serial memory port arbiter: round-robin between instruction-fetch line
// fills and load/store accesses, with IO back-pressure and flush handling.
module mem_arbiter #(
  parameter int LINE_BYTES = 16,
  parameter int CNT_W      = 7
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_data,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [2:0]              lsb_len,
  input  logic [31:0]             lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic [7:0]              mem_din,
  input  logic                    io_buffer_full,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  output logic                    busy
);

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSB = 1'b1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                  state, state_n;
  logic                    owner, last_grant;
  logic [CNT_W-1:0]        cnt, acnt, len;
  logic [1:0]              vld_pipe;
  logic [31:0]             wdata;
  logic [8*LINE_BYTES-1:0] rbuf, rbuf_n;
  logic                    lsb_elig, if_elig, grant_lsb, grant_if;
  logic                    issue, cap, last_b;
  logic [1:0]              widx;
  logic [7:0]              wnext;

  assign busy = (state != IDLE);

  always_comb begin
    lsb_elig  = lsb_req && !lsb_done && !(io_buffer_full && lsb_addr == 32'h0003_0000)
                && (lsb_wr || !clear);
    if_elig   = if_req && !if_done && !clear;
    grant_lsb = lsb_elig && (!if_elig || last_grant == OWN_IF);
    grant_if  = if_elig && !grant_lsb;
    issue     = (acnt < len);
    cap       = vld_pipe[1];
    last_b    = (cnt == len - CNT_W'(1));
    widx      = cnt[1:0] + 2'd1;
    wnext     = wdata[{widx, 3'b000} +: 8];
    // byte cnt of the line replaced by the byte arriving this cycle
    rbuf_n = rbuf;
    for (int k = 0; k < LINE_BYTES; k++)
      if (cnt == CNT_W'(k)) rbuf_n[8*k +: 8] = mem_din;
    state_n = state;
    case (state)
      IDLE:    if (grant_lsb) state_n = lsb_wr ? WRITE : READ;
               else if (grant_if) state_n = READ;
      READ:    if (clear || (cap && last_b)) state_n = IDLE;
      WRITE:   if (last_b) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_n;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      cnt        <= '0;
      acnt       <= '0;
      len        <= '0;
      vld_pipe   <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      if_done    <= 1'b0;
      lsb_done   <= 1'b0;
      if_data    <= '0;
      lsb_rdata  <= '0;
    end else if (rdy_in) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_lsb) begin
            owner      <= OWN_LSB;
            last_grant <= OWN_LSB;
            mem_a      <= lsb_addr;
            len        <= CNT_W'(lsb_len);
            cnt        <= '0;
            acnt       <= CNT_W'(1);
            vld_pipe   <= 2'b01;
            rbuf       <= '0;
            wdata      <= lsb_wdata;
            mem_wr     <= lsb_wr;
            if (lsb_wr) mem_dout <= lsb_wdata[7:0];
          end else if (grant_if) begin
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            mem_a      <= if_addr;
            len        <= CNT_W'(LINE_BYTES);
            cnt        <= '0;
            acnt       <= CNT_W'(1);
            vld_pipe   <= 2'b01;
            rbuf       <= '0;
            mem_wr     <= 1'b0;
          end
        end
        READ: begin
          // a flush drops the burst; nothing already captured is published
          if (!clear) begin
            if (issue) begin
              mem_a <= mem_a + 32'd1;
              acnt  <= acnt + CNT_W'(1);
            end
            vld_pipe <= {vld_pipe[0], issue};
            if (cap) begin
              rbuf <= rbuf_n;
              cnt  <= cnt + CNT_W'(1);
              if (last_b) begin
                if (owner == OWN_IF) begin
                  if_data <= rbuf_n;
                  if_done <= 1'b1;
                end else begin
                  lsb_rdata <= rbuf_n[31:0];
                  lsb_done  <= 1'b1;
                end
              end
            end
          end
        end
        WRITE: begin
          if (last_b) begin
            mem_wr   <= 1'b0;
            lsb_done <= 1'b1;
          end else begin
            mem_a    <= mem_a + 32'd1;
            mem_dout <= wnext;
            cnt      <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int LB = 16;
  localparam int CW = 7;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear, if_req, lsb_req, lsb_wr, io_buffer_full;
  logic [2:0] lsb_len;
  logic [31:0] if_addr, lsb_addr, lsb_wdata;
  logic [7:0] mem_din;
  logic if_done, lsb_done, mem_wr, busy;
  logic [8*LB-1:0] if_data;
  logic [31:0] lsb_rdata, mem_a;
  logic [7:0] mem_dout;

  mem_arbiter #(.LINE_BYTES(LB), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy));

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [8*LB-1:0] act, input logic [8*LB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory environment: unwritten bytes read as addr[7:0]^0x5A
  logic [7:0] ram [logic [31:0]];
  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'h5A;
  endfunction
  initial begin
    mem_din = 8'h00;
    forever begin
      @(posedge clk_in);
      if (rdy_in) mem_din <= rd(mem_a);
    end
  end
  initial forever begin
    @(negedge clk_in);
    if (mem_wr && !rst_in) ram[mem_a] = mem_dout;
  end

  // transaction-level model: edges counted from the grant edge
  localparam int K_IF = 0, K_LD = 1, K_ST = 2;
  bit m_valid = 0, m_busy, m_lastg_lsb;
  int m_kind, m_n, m_k;
  logic [31:0] m_addr, m_wd;
  logic e_if_done, e_lsb_done, e_wr;
  logic [31:0] e_a, e_rdata;
  logic [7:0] e_dout;
  logic [8*LB-1:0] e_ifdata;

  initial begin : model
    bit le, ie, od_if, od_lsb;
    forever begin
      @(posedge clk_in);
      if (rst_in) begin
        m_valid = 1; m_busy = 0; m_lastg_lsb = 0;
        e_if_done = 0; e_lsb_done = 0; e_wr = 0; e_a = 0; e_rdata = 0;
        e_dout = 0; e_ifdata = '0;
      end else if (rdy_in && m_valid) begin
        od_if = e_if_done; od_lsb = e_lsb_done;
        e_if_done = 0; e_lsb_done = 0;
        if (!m_busy) begin
          le = lsb_req && !od_lsb && !(io_buffer_full && lsb_addr == 32'h30000)
               && (lsb_wr || !clear);
          ie = if_req && !od_if && !clear;
          if (le && (!ie || !m_lastg_lsb)) begin
            m_busy = 1; m_k = 0; m_lastg_lsb = 1;
            m_kind = lsb_wr ? K_ST : K_LD; m_addr = lsb_addr; m_n = int'(lsb_len);
            m_wd = lsb_wdata; e_a = lsb_addr; e_wr = lsb_wr;
            if (lsb_wr) e_dout = lsb_wdata[7:0];
          end else if (ie) begin
            m_busy = 1; m_k = 0; m_lastg_lsb = 0;
            m_kind = K_IF; m_addr = if_addr; m_n = LB; e_a = if_addr; e_wr = 0;
          end
        end else begin
          m_k++;
          if (m_kind == K_ST) begin
            if (m_k < m_n) begin
              e_a = m_addr + 32'(m_k); e_dout = m_wd[8*m_k +: 8];
            end else begin
              e_wr = 0; e_lsb_done = 1; m_busy = 0;
            end
          end else if (clear) begin
            m_busy = 0;
          end else begin
            e_a = m_addr + 32'((m_k < m_n - 1) ? m_k : m_n - 1);
            if (m_k == m_n + 1) begin
              m_busy = 0;
              if (m_kind == K_IF) begin
                for (int i = 0; i < LB; i++) e_ifdata[8*i +: 8] = rd(m_addr + 32'(i));
                e_if_done = 1;
              end else begin
                e_rdata = 0;
                for (int i = 0; i < m_n; i++) e_rdata[8*i +: 8] = rd(m_addr + 32'(i));
                e_lsb_done = 1;
              end
            end
          end
        end
      end
    end
  end

  // single per-cycle compare process
  initial forever begin
    @(negedge clk_in);
    if (m_valid) begin
      chk("busy", busy, m_busy);
      chk("mem_a", mem_a, e_a);
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_dout", mem_dout, e_dout);
      chk("if_done", if_done, e_if_done);
      chk("lsb_done", lsb_done, e_lsb_done);
      chk("if_data", if_data, e_ifdata);
      chk("lsb_rdata", lsb_rdata, e_rdata);
    end
  end

  // requesters: hold req until done, then take the next queued item
  typedef struct {logic wr; logic [2:0] len; logic [31:0] addr; logic [31:0] wd;} lop_t;
  lop_t lq[$];
  logic [31:0] iq[$];
  initial forever begin
    @(negedge clk_in);
    if (if_req && if_done) if_req = 0;
    if (!if_req && iq.size() > 0) begin if_addr = iq.pop_front(); if_req = 1; end
  end
  initial begin : lreq
    lop_t op;
    forever begin
      @(negedge clk_in);
      if (lsb_req && lsb_done) lsb_req = 0;
      if (!lsb_req && lq.size() > 0) begin
        op = lq.pop_front();
        lsb_wr = op.wr; lsb_len = op.len; lsb_addr = op.addr; lsb_wdata = op.wd;
        lsb_req = 1;
      end
    end
  end

  // grant / done log
  logic [31:0] gq[$];
  int cyc = 0, gcyc = 0, ldone_cyc = 0, if_done_n = 0;
  bit pb = 0;
  initial forever begin
    @(negedge clk_in);
    cyc++;
    if (busy && !pb) begin gq.push_back(mem_a); gcyc = cyc; end
    if (lsb_done) ldone_cyc = cyc;
    if (if_done) if_done_n++;
    pb = busy;
  end

  task automatic fail_timeout(input string nm);
    n_chk++; n_err++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  task automatic wait_idle(input string nm);
    int i = 0;
    while (i < 400 && (iq.size() != 0 || lq.size() != 0 || if_req || lsb_req || busy)) begin
      @(negedge clk_in); i++;
    end
    if (i >= 400) fail_timeout(nm);
    @(negedge clk_in);
  endtask

  task automatic wait_addr(input logic [31:0] a, input string nm);
    int i = 0;
    while (i < 100 && !(busy && mem_a == a)) begin @(negedge clk_in); i++; end
    if (i >= 100) fail_timeout(nm);
  endtask

  task automatic sync_push;
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset;
    @(negedge clk_in); rst_in = 1;
    @(negedge clk_in); rst_in = 0;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; clear = 0; if_req = 0; lsb_req = 0; lsb_wr = 0;
    io_buffer_full = 0; lsb_len = 0; if_addr = 0; lsb_addr = 0; lsb_wdata = 0;
    repeat (3) @(negedge clk_in);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_lsb_rdata", lsb_rdata, 0);
    rst_in = 0;

    // LW at 0x100
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    gq.delete(); sync_push(); lq.push_back('{1'b0, 3'd4, 32'h100, 32'h0});
    wait_idle("lw");
    chk("lw_data", lsb_rdata, 32'h44332211);
    chk("lw_latency", ldone_cyc - gcyc, 5);

    // SH 0xBEEF to 0x200
    sync_push(); lq.push_back('{1'b1, 3'd2, 32'h200, 32'h0000BEEF});
    wait_idle("sh");
    chk("sh_b0", rd(32'h200), 8'hEF);
    chk("sh_b1", rd(32'h201), 8'hBE);
    chk("sh_latency", ldone_cyc - gcyc, 2);

    // tie after reset: LSB first, then alternate
    do_reset(); gq.delete();
    sync_push();
    iq.push_back(32'h1000); iq.push_back(32'h1010);
    lq.push_back('{1'b0, 3'd4, 32'h300, 32'h0}); lq.push_back('{1'b0, 3'd2, 32'h310, 32'h0});
    wait_idle("rr");
    chk("rr_n", gq.size(), 4);
    if (gq.size() == 4) begin
      chk("rr_g0", gq[0], 32'h300);
      chk("rr_g1", gq[1], 32'h1000);
      chk("rr_g2", gq[2], 32'h310);
      chk("rr_g3", gq[3], 32'h1010);
    end

    // SB to IO address held off by io_buffer_full
    gq.delete(); io_buffer_full = 1;
    sync_push();
    lq.push_back('{1'b1, 3'd1, 32'h30000, 32'h000000A5}); iq.push_back(32'h2000);
    repeat (5) @(negedge clk_in);
    io_buffer_full = 0;
    wait_idle("io");
    chk("io_n", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("io_g0", gq[0], 32'h2000);
      chk("io_g1", gq[1], 32'h30000);
    end
    chk("io_byte", rd(32'h30000), 8'hA5);

    // fetch aborted by clear at the capture of byte 3, then refetched
    if_done_n = 0;
    sync_push(); iq.push_back(32'h1000);
    wait_addr(32'h1003, "clr_addr");
    @(negedge clk_in); clear = 1;
    @(negedge clk_in); clear = 0;
    chk("clr_busy", busy, 0);
    wait_idle("clr");
    chk("clr_ndone", if_done_n, 1);
    chk("clr_b0", if_data[7:0], 8'h5A);
    chk("clr_b15", if_data[127:120], 8'h55);

    // SW survives a clear mid-burst
    sync_push(); lq.push_back('{1'b1, 3'd4, 32'h400, 32'hDEADBEEF});
    wait_addr(32'h401, "sw_addr");
    clear = 1;
    @(negedge clk_in); clear = 0;
    wait_idle("sw");
    chk("sw_word", {rd(32'h403), rd(32'h402), rd(32'h401), rd(32'h400)}, 32'hDEADBEEF);

    // rdy_in low mid-read, half-word zero-filled
    sync_push(); lq.push_back('{1'b0, 3'd2, 32'h500, 32'h0});
    wait_addr(32'h500, "rdy_addr");
    rdy_in = 0;
    repeat (3) @(negedge clk_in);
    rdy_in = 1;
    wait_idle("rdy");
    chk("rdy_data", lsb_rdata, 32'h00005B5A);

    // address wrap
    sync_push(); lq.push_back('{1'b0, 3'd4, 32'hFFFFFFFE, 32'h0});
    wait_idle("wrap");
    chk("wrap_data", lsb_rdata, 32'h5B5AA5A4);

    // reset mid-read
    sync_push(); iq.push_back(32'h3000);
    wait_addr(32'h3004, "rst_addr");
    rst_in = 1;
    @(negedge clk_in);
    chk("mrst_mem_a", mem_a, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_if_data", if_data, 0);
    chk("mrst_lsb_rdata", lsb_rdata, 0);
    rst_in = 0;
    wait_idle("mrst");
    chk("mrst_refetch_b4", if_data[39:32], 8'h5E);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
